// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/opcode bundle between the EX stage and the M-extension unit
interface ex_mdu_if;
  logic [7:0] aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [5:0] stall;
  logic [31:0] result_o;
  logic is_mdu_o;
  logic stallreq_o;
  modport master (output aluop_i, reg1_i, reg2_i, stall, input result_o, is_mdu_o, stallreq_o);
  modport slave (input aluop_i, reg1_i, reg2_i, stall, output result_o, is_mdu_o, stallreq_o);
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: single-cycle multiplier plus 32-cycle restoring divider for the EX stage
module ex_mdu (
  input logic clk,
  input logic rst,
  ex_mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [31:0] q, r, d;
  logic neg_q, neg_r;
  logic is_mul, is_div, sgn, sa, sb;
  logic [31:0] a_abs, b_abs, q_nxt, r_nxt;
  logic [32:0] sh, diff;
  logic [63:0] prod;
  logic unused;
  assign unused = ^{bus.stall[5:4], bus.stall[2:0]};
  always_comb begin
    is_mul = bus.aluop_i[7:2] == 6'b100000;
    is_div = bus.aluop_i[7:2] == 6'b100001;
    sgn = ~bus.aluop_i[0];
    sa = bus.aluop_i[1] ^ bus.aluop_i[0];
    sb = bus.aluop_i[1:0] == 2'b01;
    prod = {{32{sa & bus.reg1_i[31]}}, bus.reg1_i} * {{32{sb & bus.reg2_i[31]}}, bus.reg2_i};
    a_abs = (sgn && bus.reg1_i[31]) ? -bus.reg1_i : bus.reg1_i;
    b_abs = (sgn && bus.reg2_i[31]) ? -bus.reg2_i : bus.reg2_i;
    sh = {r, q[31]};
    diff = sh - {1'b0, d};
    q_nxt = {q[30:0], ~diff[32]};
    r_nxt = diff[32] ? sh[31:0] : diff[31:0];
  end
  assign bus.is_mdu_o = is_mul | is_div;
  assign bus.stallreq_o = is_div && state != END;
  assign bus.result_o = is_mul ? (bus.aluop_i[1:0] == 2'b00 ? prod[31:0] : prod[63:32]) :
                        (is_div && state == END) ? (bus.aluop_i[1] ? r : q) : 32'd0;
  // q doubles as the shifting dividend; signs are fixed up once, on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 6'd0;
      q <= 32'd0;
      r <= 32'd0;
      d <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_div) begin
          q <= a_abs;
          d <= b_abs;
          r <= 32'd0;
          cnt <= 6'd0;
          neg_q <= sgn & (bus.reg1_i[31] ^ bus.reg2_i[31]);
          neg_r <= sgn & bus.reg1_i[31];
          state <= bus.reg2_i == 32'd0 ? BYZERO : ON;
        end
        BYZERO: if (!is_div) state <= IDLE;
        else begin
          q <= 32'hFFFF_FFFF;
          r <= neg_r ? -q : q;
          state <= END;
        end
        ON: if (!is_div) state <= IDLE;
        else begin
          cnt <= cnt + 6'd1;
          q <= (cnt == 6'd31 && neg_q) ? -q_nxt : q_nxt;
          r <= (cnt == 6'd31 && neg_r) ? -r_nxt : r_nxt;
          if (cnt == 6'd31) state <= END;
        end
        END: if (!bus.stall[3]) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: scoreboard bench for ex_mdu covering multiply, divide, abort, reset and hold
module tb_ex_mdu;
  logic clk = 1'b0;
  logic rst;
  int vecs = 0;
  int errs = 0;
  logic [31:0] sbq[$];
  ex_mdu_if bus ();
  ex_mdu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (op)
      8'h80: begin p = ua * ub; return p[31:0]; end
      8'h81: begin p = sa * sb; return p[63:32]; end
      8'h82: begin p = sa * ub; return p[63:32]; end
      8'h83: begin p = ua * ub; return p[63:32]; end
      8'h84: return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
      8'h85: return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
      8'h86: return b == 0 ? a : 32'(sa % sb);
      8'h87: return b == 0 ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_stall(input logic [7:0] op, input logic [31:0] b);
    if (op < 8'h84 || op > 8'h87) return 0;
    return b == 0 ? 2 : 33;
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    bus.aluop_i = op;
    bus.reg1_i = a;
    bus.reg2_i = b;
    sbq.push_back(exp);
    #1;
    while (bus.stallreq_o && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("stall op=%h", op), n, exp_stall(op, b));
    chk($sformatf("is_mdu op=%h", op), {31'd0, bus.is_mdu_o}, {31'd0, op >= 8'h80 && op <= 8'h87});
    chk($sformatf("result op=%h a=%h b=%h", op, a, b), bus.result_o, sbq.pop_front());
  endtask

  initial begin
    logic [7:0] op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.aluop_i = 8'h00;
    bus.reg1_i = 32'd0;
    bus.reg2_i = 32'd0;
    bus.stall = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset result", bus.result_o, 32'd0);
    chk("reset is_mdu", {31'd0, bus.is_mdu_o}, 32'd0);
    chk("reset stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    do_op(8'h84, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    do_op(8'h86, 32'd100, 32'hFFFF_FFF9, 32'd2);
    do_op(8'h85, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    do_op(8'h87, 32'h1234, 32'd0, 32'h1234);
    do_op(8'h84, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
    do_op(8'h86, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    do_op(8'h84, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op(8'h86, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_op(8'h81, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op(8'h82, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(8'h80, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    do_op(8'h83, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(8'h88, 32'd5, 32'd3, 32'd0);
    do_op(8'h7F, 32'd5, 32'd3, 32'd0);
    for (int i = 0; i < 12; i++) begin
      op = 8'h80 + 8'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 3) b = 32'd0;
      do_op(op, a, b, model(op, a, b));
    end
    // reset in the middle of a division, at counter 10
    @(negedge clk);
    bus.aluop_i = 8'h84;
    bus.reg1_i = 32'd100;
    bus.reg2_i = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    chk("pre-reset stallreq", {31'd0, bus.stallreq_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.aluop_i = 8'h00;
    #1;
    chk("post-reset stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    chk("post-reset result", bus.result_o, 32'd0);
    do_op(8'h84, 32'd100, 32'd7, 32'd14);
    // abort by withdrawing the divide op
    @(negedge clk);
    bus.aluop_i = 8'h85;
    bus.reg1_i = 32'd99;
    bus.reg2_i = 32'd4;
    repeat (5) @(negedge clk);
    bus.aluop_i = 8'h00;
    @(negedge clk);
    #1;
    chk("abort stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    chk("abort result", bus.result_o, 32'd0);
    do_op(8'h85, 32'd7, 32'd2, 32'd3);
    // hold in END under stall[3], then back-to-back
    do_op(8'h84, 32'd1000, 32'd3, 32'd333);
    bus.stall = 6'b001000;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("hold result", bus.result_o, 32'd333);
      chk("hold stallreq", {31'd0, bus.stallreq_o}, 32'd0);
    end
    bus.stall = 6'd0;
    do_op(8'h85, 32'd7, 32'd2, 32'd3);
    do_op(8'h87, 32'd7, 32'd2, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
